// File: rtl/nios2_debug_scan_master_if.sv
// nios2_debug_scan_master_if: command/response handshake plus the virtual-JTAG slave signals.
// master modport = scan master side (accepts commands, drives vji_* strobes/TCK/TDI).
// slave modport  = environment side (issues commands, models the debug slave).
// DEBUG_SCAN_ABORT_EN adds abort / rsp_aborted.
interface nios2_debug_scan_master_if #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_data;
    logic                rsp_valid;
    logic [DR_WIDTH-1:0] rsp_data;
    logic [IR_WIDTH-1:0] rsp_ir_out;
    logic                busy;
    logic                vji_tck;
    logic                vji_tdi;
    logic                vji_tdo;
    logic [IR_WIDTH-1:0] vji_ir_in;
    logic [IR_WIDTH-1:0] vji_ir_out;
    logic                vji_uir;
    logic                vji_cdr;
    logic                vji_sdr;
    logic                vji_udr;
    logic                vji_rti;
`ifdef DEBUG_SCAN_ABORT_EN
    logic                abort;
    logic                rsp_aborted;
`endif

    modport master (
`ifdef DEBUG_SCAN_ABORT_EN
        input  abort,
        output rsp_aborted,
`endif
        input  cmd_valid, cmd_ir, cmd_data, vji_tdo, vji_ir_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_ir_out, busy,
        output vji_tck, vji_tdi, vji_ir_in,
        output vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );

    modport slave (
`ifdef DEBUG_SCAN_ABORT_EN
        output abort,
        input  rsp_aborted,
`endif
        output cmd_valid, cmd_ir, cmd_data, vji_tdo, vji_ir_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out, busy,
        input  vji_tck, vji_tdi, vji_ir_in,
        input  vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );
endinterface

// File: rtl/nios2_debug_scan_master.sv
// nios2_debug_scan_master: runs one virtual-JTAG scan (UIR, CDR, SDR x DR_WIDTH, UDR, RTI) per accepted command.
// Latency: (DR_WIDTH+4)*2*TCK_DIV clk from the accept edge to the one-cycle rsp_valid pulse.
// Backpressure: cmd_ready high only in IDLE; commands offered while busy are ignored, not queued.
// Ports: clk, reset_n (async active-low), bus (nios2_debug_scan_master_if.master: cmd/rsp + vji_*).
// Optional: define DEBUG_SCAN_ABORT_EN to add abort (SDR -> RTI, skipping UDR) and rsp_aborted.
module nios2_debug_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    nios2_debug_scan_master_if.master        bus
);
    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int CNT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UIR  = 3'd1,
        S_CDR  = 3'd2,
        S_SDR  = 3'd3,
        S_UDR  = 3'd4,
        S_RTI  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                tck_q, tck_d;
    logic                tdi_q, tdi_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DR_WIDTH-1:0] shift_q, shift_d;
    logic [DR_WIDTH-1:0] cap_q, cap_d;
    logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
    logic [IR_WIDTH-1:0] ir_cap_q, ir_cap_d;
    logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;
    logic                rsp_valid_q, rsp_valid_d;
`ifdef DEBUG_SCAN_ABORT_EN
    logic                aborted_q, aborted_d;
    logic                rsp_aborted_q, rsp_aborted_d;
`endif

    logic accept, div_last, tck_rise, tck_fall, sdr_last, abort_req;
    logic [DR_WIDTH-1:0] shift_nxt;

    assign accept    = bus.cmd_valid && (state_q == S_IDLE);
    assign div_last  = (div_q == DIV_LAST);
    // TCK edges are decided one clk ahead so the state/strobe/TDI update lands on the same edge as TCK.
    assign tck_rise  = (state_q != S_IDLE) && !tck_q && div_last;
    assign tck_fall  = (state_q != S_IDLE) &&  tck_q && div_last;
    assign sdr_last  = (bit_cnt_q == CNT_LAST);
    assign shift_nxt = shift_q >> 1;
`ifdef DEBUG_SCAN_ABORT_EN
    assign abort_req = bus.abort && (state_q == S_SDR) && tck_fall;
`else
    assign abort_req = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic: every non-IDLE transition happens on a TCK fall
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.cmd_valid) state_d = S_UIR;
            S_UIR:  if (tck_fall) state_d = S_CDR;
            S_CDR:  if (tck_fall) state_d = S_SDR;
            S_SDR:  if (tck_fall) begin
                        if (abort_req)     state_d = S_RTI;
                        else if (sdr_last) state_d = S_UDR;
                    end
            S_UDR:  if (tck_fall) state_d = S_RTI;
            S_RTI:  if (tck_fall) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-value logic
    always_comb begin
        div_d      = div_q;
        tck_d      = tck_q;
        tdi_d      = tdi_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        cap_d      = cap_q;
        rsp_data_d = rsp_data_q;
        ir_in_d    = ir_in_q;
        ir_cap_d   = ir_cap_q;
        rsp_ir_d   = rsp_ir_q;
        rsp_valid_d = 1'b0;
`ifdef DEBUG_SCAN_ABORT_EN
        aborted_d     = aborted_q;
        rsp_aborted_d = rsp_aborted_q;
`endif

        if (state_q == S_IDLE) begin
            div_d = '0;
            tck_d = 1'b0;
        end else begin
            div_d = div_last ? '0 : div_q + 1'b1;
            if (div_last) tck_d = ~tck_q;
        end

        if (accept) begin
            shift_d   = bus.cmd_data;
            cap_d     = '0;
            ir_in_d   = bus.cmd_ir;
            bit_cnt_d = '0;
`ifdef DEBUG_SCAN_ABORT_EN
            aborted_d = 1'b0;
`endif
        end

        if (tck_rise && state_q == S_CDR) ir_cap_d = bus.vji_ir_out;
        // TDO enters at the MSB so after DR_WIDTH samples the first bit sits at [0]
        if (tck_rise && state_q == S_SDR) cap_d = {bus.vji_tdo, cap_q[DR_WIDTH-1:1]};

        if (tck_fall) begin
            case (state_q)
                S_CDR: begin
                    tdi_d     = shift_q[0];
                    bit_cnt_d = '0;
                end
                S_SDR: begin
                    if (abort_req) begin
                        tdi_d = 1'b0;
                        // Realign the partial capture so captured bits start at [0], rest zero
                        cap_d = cap_q >> (CNT_LAST - bit_cnt_q);
`ifdef DEBUG_SCAN_ABORT_EN
                        aborted_d = 1'b1;
`endif
                    end else if (sdr_last) begin
                        tdi_d = 1'b0;
                    end else begin
                        shift_d   = shift_nxt;
                        tdi_d     = shift_nxt[0];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                S_RTI: begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = cap_q;
                    rsp_ir_d    = ir_cap_q;
`ifdef DEBUG_SCAN_ABORT_EN
                    rsp_aborted_d = aborted_q;
`endif
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q       <= '0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            cap_q       <= '0;
            rsp_data_q  <= '0;
            ir_in_q     <= '0;
            ir_cap_q    <= '0;
            rsp_ir_q    <= '0;
            rsp_valid_q <= 1'b0;
`ifdef DEBUG_SCAN_ABORT_EN
            aborted_q     <= 1'b0;
            rsp_aborted_q <= 1'b0;
`endif
        end else begin
            div_q       <= div_d;
            tck_q       <= tck_d;
            tdi_q       <= tdi_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            cap_q       <= cap_d;
            rsp_data_q  <= rsp_data_d;
            ir_in_q     <= ir_in_d;
            ir_cap_q    <= ir_cap_d;
            rsp_ir_q    <= rsp_ir_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef DEBUG_SCAN_ABORT_EN
            aborted_q     <= aborted_d;
            rsp_aborted_q <= rsp_aborted_d;
`endif
        end
    end

    // Output logic: one strobe per non-IDLE state
    always_comb begin
        bus.cmd_ready  = (state_q == S_IDLE);
        bus.busy       = (state_q != S_IDLE);
        bus.vji_uir    = (state_q == S_UIR);
        bus.vji_cdr    = (state_q == S_CDR);
        bus.vji_sdr    = (state_q == S_SDR);
        bus.vji_udr    = (state_q == S_UDR);
        bus.vji_rti    = (state_q == S_RTI);
        bus.vji_tck    = tck_q;
        bus.vji_tdi    = tdi_q;
        bus.vji_ir_in  = ir_in_q;
        bus.rsp_valid  = rsp_valid_q;
        bus.rsp_data   = rsp_data_q;
        bus.rsp_ir_out = rsp_ir_q;
`ifdef DEBUG_SCAN_ABORT_EN
        bus.rsp_aborted = rsp_aborted_q;
`endif
    end
endmodule

// File: doc/nios2_debug_scan_master.md
Name: nios2_debug_scan_master

Overview:
Host-side initiator for the Nios II debug slave's virtual-JTAG interface. It drives the virtual-JTAG state strobes, IR value, TCK and TDI, and captures TDO. This lets on-chip logic or a simulation bench issue complete DR scan transactions (IR select plus a 38-bit shift) to the CPU debug slave without a physical JTAG cable. It sits between a simple command/response port and the debug slave's vji_* signals.

Parameters:
DR_WIDTH, 38, data-register scan length in bits
IR_WIDTH, 2, virtual IR width
TCK_DIV, 2, clk cycles per TCK half-period; legal range is 1 or more

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accept; high only in IDLE
cmd_ir  in  IR_WIDTH  IR value for this scan
cmd_data  in  DR_WIDTH  data to shift in, LSB first
rsp_valid  out  1  one-cycle pulse; scan complete
rsp_data  out  DR_WIDTH  TDO bits captured, LSB first
rsp_ir_out  out  IR_WIDTH  vji_ir_out sampled during CDR
busy  out  1  high from accept until rsp_valid
vji_tck  out  1  generated TCK
vji_tdi  out  1  serial data to slave
vji_tdo  in  1  serial data from slave
vji_ir_in  out  IR_WIDTH  IR presented to slave
vji_ir_out  in  IR_WIDTH  slave IR status
vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual-state strobes

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous, active-low, on reset_n.
- Reset values: every output is 0, except cmd_ready=1. FSM goes to IDLE; shift and capture registers clear to 0.
- Reset mid-scan: all scan state is abandoned and the outputs return to reset values within the same reset. No rsp_valid is produced for the abandoned scan.
- FSM states: IDLE, UIR, CDR, SDR, UDR, RTI.
- Handshake: a command is accepted on a clk edge where cmd_valid && cmd_ready. On accept:
  - cmd_data is loaded into the shift register.
  - vji_ir_in <= cmd_ir; it holds that value until the next accept.
  - The FSM enters UIR.
  - cmd_ready drops and busy rises.
- TCK generation:
  - In IDLE, vji_tck is held at 0 and the divider is held at 0.
  - Otherwise the divider counts 0..TCK_DIV-1, and vji_tck toggles when it reaches TCK_DIV-1.
  - One TCK period is 2*TCK_DIV clk cycles, starting with the low half.
- State sequencing: each of UIR, CDR, UDR and RTI lasts exactly one TCK period. SDR lasts DR_WIDTH TCK periods.
- State changes, strobe updates and vji_tdi updates occur on the clk edge where TCK falls, i.e. at each TCK period boundary.
- Strobes: exactly one strobe is high per non-IDLE state, matching that state. All strobes are low in IDLE.
- Shifting:
  - On entry to SDR, vji_tdi = shift[0]. On each subsequent TCK fall within SDR, the register shifts right and vji_tdi takes the new bit 0.
  - vji_tdo is sampled on the clk edge where TCK rises and inserted MSB-first into the capture register, so the first sampled bit ends up in rsp_data[0].
  - An SDR bit counter runs from 0 to DR_WIDTH-1. On leaving SDR, vji_tdi returns to 0.
- CDR capture: vji_ir_out is sampled at the TCK rise in CDR and presented on rsp_ir_out.
- Completion and latency:
  - At the end of the RTI period the FSM returns to IDLE.
  - rsp_valid pulses for one clk on that edge; busy drops and cmd_ready rises on the same edge.
  - rsp_data and rsp_ir_out hold their values until the next rsp_valid.
  - Total latency from the accept edge to rsp_valid is (DR_WIDTH+4)*2*TCK_DIV clk cycles.
- Back-to-back commands: a command may be accepted on the cycle immediately after rsp_valid. cmd_valid presented while busy is ignored, not queued.
- Inputs: cmd_ir and cmd_data are sampled only at accept; changes while busy have no effect.

Optional Feature:
DEBUG_SCAN_ABORT_EN
- Enabled: adds input abort (1 bit) and output rsp_aborted (1 bit).
  - If abort is high on a TCK-fall edge while in SDR, the FSM skips UDR and goes directly to RTI, so the slave register is not updated.
  - rsp_valid then pulses with rsp_aborted=1, and rsp_data holds the bits captured so far. Uncaptured bits are 0.
  - abort in any other state is ignored. A normal completion gives rsp_aborted=0.
- Disabled: neither port exists, and every scan runs the full sequence.

Test Plan:
1. Reset mid-SDR (reset_n low at bit 10) -> all strobes, vji_tck and busy are 0, cmd_ready=1, and no rsp_valid follows.
2. TCK_DIV=2: accept cmd_ir=2'b01, cmd_data=38'h15_5555_5555 -> strobe order is uir, cdr, sdr(x38), udr, rti, each aligned to 4-clk TCK periods. rsp_valid arrives exactly 168 clks after accept. Bench records vji_tdi at each TCK rise in SDR and must see 38'h15_5555_5555 LSB first.
3. Slave model preloads 38'h2A_AAAA_AAAA at CDR and drives vji_ir_out=2'b10 -> rsp_data=38'h2A_AAAA_AAAA and rsp_ir_out=2'b10.
4. cmd_valid held high continuously across two commands -> second accept occurs on the cycle after the first rsp_valid. vji_ir_in changes only at accept. cmd_valid pulses while busy are not accepted.
5. TCK_DIV=1, DR_WIDTH=38 -> TCK period is 2 clks and latency is 84 clks. A single-bit slave pattern 38'h1 yields rsp_data=38'h1.
6. (DEBUG_SCAN_ABORT_EN) abort asserted at SDR bit 5 -> no udr strobe occurs, rti follows, rsp_aborted=1, and rsp_data[37:6]=0.
